// File: rtl/deck_draw_arbiter.sv
// Round-robin arbiter that lends the single card deck to one requester at a time
// and streams that requester's cards out one draw1 pulse per card.
module deck_draw_arbiter #(
  parameter int  N_PLAYERS  = 4,
  parameter int  CNT_W      = 4,
  parameter int  SETTLE_CYC = 2,
  parameter int  TIMEOUT    = 64,
  localparam int IDX_W      = $clog2(N_PLAYERS)
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [N_PLAYERS-1:0]       i_req,
  input  logic [CNT_W*N_PLAYERS-1:0] i_req_num,
  input  logic                       i_deck_done,
  input  logic [5:0]                 i_deck_card,
  input  logic                       i_deck_empty,
  output logic                       o_deck_draw1,
  output logic [N_PLAYERS-1:0]       o_grant,
  output logic [5:0]                 o_card,
  output logic                       o_card_valid,
  output logic [IDX_W-1:0]           o_card_player,
  output logic [N_PLAYERS-1:0]       o_ack,
  output logic                       o_busy,
  output logic                       o_stall
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_SETTLE = 2'd2;
  localparam logic [1:0] S_ACK    = 2'd3;

  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam int SET_W  = $clog2(SETTLE_CYC + 1);

  logic [1:0]           state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [IDX_W-1:0]     last_grant_q, last_grant_d;
  logic [CNT_W-1:0]     remaining_q, remaining_d;
  logic [WAIT_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic [SET_W-1:0]     settle_cnt_q, settle_cnt_d;
  logic [5:0]           card_q, card_d;
  logic [IDX_W-1:0]     card_player_q, card_player_d;
  logic [N_PLAYERS-1:0] grant_q, grant_d;
  logic [N_PLAYERS-1:0] ack_q, ack_d;
  logic                 draw1_q, draw1_d;
  logic                 card_valid_q, card_valid_d;
  logic                 stall_q, stall_d;
  logic                 busy_q;

  // Deck-empty only explains a stall to the outside world; the FSM keys off deck_done.
  logic deck_empty_unused;
  assign deck_empty_unused = i_deck_empty;

  // Round-robin pick: rotate the request vector so the slot after last_grant sits at bit 0.
  logic [2*N_PLAYERS-1:0] req_rot;
  logic                   pick_found;
  logic [IDX_W-1:0]       pick_idx;
  logic [CNT_W-1:0]       pick_num;

  always_comb begin
    int slot;
    slot       = 0;
    req_rot    = {i_req, i_req} >> (last_grant_q + IDX_W'(1));
    pick_found = 1'b0;
    pick_idx   = '0;
    pick_num   = '0;
    for (int j = 0; j < N_PLAYERS; j++) begin
      if (!pick_found && req_rot[j]) begin
        pick_found = 1'b1;
        slot       = int'(last_grant_q) + 1 + j;
        if (slot >= N_PLAYERS) slot = slot - N_PLAYERS;
        pick_idx   = IDX_W'(slot);
      end
    end
    for (int p = 0; p < N_PLAYERS; p++) begin
      if (IDX_W'(p) == pick_idx) pick_num = i_req_num[p*CNT_W +: CNT_W];
    end
  end

  // NOTE: every next-state signal takes its held value first, so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    last_grant_d  = last_grant_q;
    remaining_d   = remaining_q;
    wait_cnt_d    = wait_cnt_q;
    settle_cnt_d  = settle_cnt_q;
    card_d        = card_q;
    card_player_d = card_player_q;
    grant_d       = grant_q;
    stall_d       = stall_q;
    ack_d         = '0;
    draw1_d       = 1'b0;
    card_valid_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        // ack_q still high means the finished requester has not yet seen it and dropped i_req.
        if (pick_found && (ack_q == '0)) begin
          idx_d       = pick_idx;
          remaining_d = pick_num;
          grant_d     = N_PLAYERS'(1) << pick_idx;
          wait_cnt_d  = '0;
          state_d     = (pick_num == '0) ? S_ACK : S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_deck_done) begin
          card_d        = i_deck_card;
          card_player_d = idx_q;
          card_valid_d  = 1'b1;
          draw1_d       = 1'b1;
          remaining_d   = remaining_q - CNT_W'(1);
          wait_cnt_d    = '0;
          stall_d       = 1'b0;
          settle_cnt_d  = '0;
          state_d       = S_SETTLE;
        end else begin
          if (wait_cnt_q != WAIT_W'(TIMEOUT)) wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          stall_d = (wait_cnt_d == WAIT_W'(TIMEOUT));
        end
      end
      S_SETTLE: begin
        if (settle_cnt_q == SET_W'(SETTLE_CYC)) begin
          state_d = (remaining_q == '0) ? S_ACK : S_WAIT;
        end else begin
          settle_cnt_d = settle_cnt_q + SET_W'(1);
        end
      end
      default: begin
        ack_d        = grant_q;
        grant_d      = '0;
        last_grant_d = idx_q;
        state_d      = S_IDLE;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      last_grant_q  <= IDX_W'(N_PLAYERS - 1);
      remaining_q   <= '0;
      wait_cnt_q    <= '0;
      settle_cnt_q  <= '0;
      card_q        <= '0;
      card_player_q <= '0;
      grant_q       <= '0;
      ack_q         <= '0;
      draw1_q       <= 1'b0;
      card_valid_q  <= 1'b0;
      stall_q       <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      last_grant_q  <= last_grant_d;
      remaining_q   <= remaining_d;
      wait_cnt_q    <= wait_cnt_d;
      settle_cnt_q  <= settle_cnt_d;
      card_q        <= card_d;
      card_player_q <= card_player_d;
      grant_q       <= grant_d;
      ack_q         <= ack_d;
      draw1_q       <= draw1_d;
      card_valid_q  <= card_valid_d;
      stall_q       <= stall_d;
      busy_q        <= (state_d != S_IDLE);
    end
  end

  assign o_deck_draw1  = draw1_q;
  assign o_grant       = grant_q;
  assign o_card        = card_q;
  assign o_card_valid  = card_valid_q;
  assign o_card_player = card_player_q;
  assign o_ack         = ack_q;
  assign o_busy        = busy_q;
  assign o_stall       = stall_q;

endmodule

// File: tb/tb_deck_draw_arbiter.sv
// Directed bench for deck_draw_arbiter: single/multi draw, round-robin order,
// deck stall timeout, zero-count grant and reset mid-transfer.
module tb_deck_draw_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [3:0]  i_req;
  logic [15:0] i_req_num;
  logic        i_deck_done;
  logic [5:0]  i_deck_card;
  logic        i_deck_empty;
  logic        o_deck_draw1;
  logic [3:0]  o_grant;
  logic [5:0]  o_card;
  logic        o_card_valid;
  logic [1:0]  o_card_player;
  logic [3:0]  o_ack;
  logic        o_busy;
  logic        o_stall;

  always #5 i_clk = ~i_clk;

  deck_draw_arbiter dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_req         (i_req),
    .i_req_num     (i_req_num),
    .i_deck_done   (i_deck_done),
    .i_deck_card   (i_deck_card),
    .i_deck_empty  (i_deck_empty),
    .o_deck_draw1  (o_deck_draw1),
    .o_grant       (o_grant),
    .o_card        (o_card),
    .o_card_valid  (o_card_valid),
    .o_card_player (o_card_player),
    .o_ack         (o_ack),
    .o_busy        (o_busy),
    .o_stall       (o_stall)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Monitor state, written only by the negedge monitor.
  int         draw_total  = 0;
  int         valid_total = 0;
  int         ack_total   = 0;
  int         b2b_total   = 0;
  logic [3:0] prev_grant  = '0;
  logic [5:0] card_log[$];
  logic [1:0] player_log[$];
  logic [3:0] grant_log[$];

  // Deck model: top card advances by one on every draw1 pulse.
  int         deck_base = 0;
  logic [5:0] deck_mem[16];
  assign i_deck_card = deck_mem[4'(draw_total - deck_base)];

  always @(negedge i_clk) begin
    if (o_deck_draw1) draw_total++;
    if (o_card_valid) begin
      valid_total++;
      card_log.push_back(o_card);
      player_log.push_back(o_card_player);
    end
    if (o_ack != '0) ack_total++;
    if (o_grant != '0 && prev_grant == '0) grant_log.push_back(o_grant);
    if (o_grant != '0 && prev_grant != '0 && o_grant != prev_grant) b2b_total++;
    prev_grant = o_grant;
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic load_deck(input logic [5:0] c0, input logic [5:0] c1,
                           input logic [5:0] c2, input logic [5:0] c3);
    deck_mem[0] = c0;
    deck_mem[1] = c1;
    deck_mem[2] = c2;
    deck_mem[3] = c3;
    deck_base   = draw_total;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!o_card_valid && n < 300);
    check({tag, "_valid_seen"}, 32'(o_card_valid), 1);
  endtask

  task automatic wait_ack(input string tag);
    int n = 0;
    do begin
      tick();
      n++;
    end while (o_ack == '0 && n < 300);
    check({tag, "_ack_seen"}, 32'(o_ack != '0), 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_grant"}, 32'(o_grant), 0);
    check({tag, "_card"}, 32'(o_card), 0);
    check({tag, "_valid"}, 32'(o_card_valid), 0);
    check({tag, "_player"}, 32'(o_card_player), 0);
    check({tag, "_ack"}, 32'(o_ack), 0);
    check({tag, "_busy"}, 32'(o_busy), 0);
    check({tag, "_stall"}, 32'(o_stall), 0);
    check({tag, "_draw1"}, 32'(o_deck_draw1), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d0, v0, c0, g0, a0, b0, n;
    logic [5:0] exp_cards[4];
    logic [3:0] exp_grants[5];

    for (int i = 0; i < 16; i++) deck_mem[i] = '0;
    i_rst = 1'b1; i_req = '0; i_req_num = '0; i_deck_done = 1'b0; i_deck_empty = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    i_rst = 1'b0;

    // 1: single draw for player 0
    load_deck(6'h05, 6'h00, 6'h00, 6'h00);
    i_deck_done = 1'b1;
    i_req_num = 16'h0001;
    i_req = 4'b0001;
    d0 = draw_total; v0 = valid_total;
    tick();
    check("t1_grant", 32'(o_grant), 32'b0001);
    check("t1_busy", 32'(o_busy), 1);
    check("t1_no_card_yet", 32'(o_card_valid), 0);
    tick();
    check("t1_valid", 32'(o_card_valid), 1);
    check("t1_draw1", 32'(o_deck_draw1), 1);
    check("t1_card", 32'(o_card), 32'h05);
    check("t1_player", 32'(o_card_player), 0);
    wait_ack("t1");
    check("t1_ack", 32'(o_ack), 32'b0001);
    check("t1_grant_drop", 32'(o_grant), 0);
    i_req = '0;
    tick();
    check("t1_idle", 32'(o_busy), 0);
    check("t1_draws", 32'(draw_total - d0), 1);
    check("t1_strobes", 32'(valid_total - v0), 1);

    // 2: four cards for player 2; other players' counts must not leak in
    load_deck(6'h11, 6'h12, 6'h13, 6'h14);
    exp_cards = '{6'h11, 6'h12, 6'h13, 6'h14};
    i_req_num = 16'h7493;
    i_req = 4'b0100;
    d0 = draw_total; v0 = valid_total; c0 = card_log.size();
    tick();
    check("t2_grant", 32'(o_grant), 32'b0100);
    wait_ack("t2");
    check("t2_ack", 32'(o_ack), 32'b0100);
    i_req = '0;
    tick();
    check("t2_draws", 32'(draw_total - d0), 4);
    check("t2_strobes", 32'(valid_total - v0), 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2_card%0d", i), 32'(card_log[c0 + i]), 32'(exp_cards[i]));
      check($sformatf("t2_player%0d", i), 32'(player_log[c0 + i]), 2);
    end

    // 3: round-robin with all four requesting, starting from reset
    i_rst = 1'b1;
    repeat (2) tick();
    i_rst = 1'b0;
    load_deck(6'h01, 6'h02, 6'h03, 6'h04);
    exp_grants = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    i_req_num = 16'h1111;
    i_req = 4'b1111;
    g0 = grant_log.size(); b0 = b2b_total; n = 0;
    while (grant_log.size() < g0 + 5 && n < 400) begin
      tick();
      n++;
    end
    check("t3_grant_count", 32'(grant_log.size() >= g0 + 5), 1);
    for (int i = 0; i < 5; i++)
      check($sformatf("t3_grant%0d", i), 32'(grant_log[g0 + i]), 32'(exp_grants[i]));
    check("t3_no_back_to_back", 32'(b2b_total - b0), 0);
    i_req = '0;
    n = 0;
    while ((o_busy || o_ack != '0) && n < 100) begin
      tick();
      n++;
    end
    tick();
    check("t3_drained", 32'(o_busy), 0);

    // 4: deck stalls for 100 cycles after the first of two cards
    load_deck(6'h21, 6'h22, 6'h00, 6'h00);
    i_deck_done = 1'b1;
    i_req_num = 16'h2000;
    i_req = 4'b1000;
    d0 = draw_total; v0 = valid_total;
    wait_valid("t4a");
    check("t4_card0", 32'(o_card), 32'h21);
    i_deck_done = 1'b0;
    repeat (40) tick();
    check("t4_stall_early", 32'(o_stall), 0);
    repeat (60) tick();
    check("t4_stall_set", 32'(o_stall), 1);
    check("t4_draws_held", 32'(draw_total - d0), 1);
    check("t4_busy_held", 32'(o_busy), 1);
    i_deck_done = 1'b1;
    tick();
    check("t4_valid1", 32'(o_card_valid), 1);
    check("t4_card1", 32'(o_card), 32'h22);
    check("t4_stall_clear", 32'(o_stall), 0);
    wait_ack("t4");
    check("t4_ack", 32'(o_ack), 32'b1000);
    i_req = '0;
    tick();
    check("t4_draws", 32'(draw_total - d0), 2);
    check("t4_strobes", 32'(valid_total - v0), 2);

    // 5: zero-count request on player 1
    i_req_num = 16'h5505;
    i_req = 4'b0010;
    d0 = draw_total; v0 = valid_total;
    tick();
    check("t5_grant", 32'(o_grant), 32'b0010);
    wait_ack("t5");
    check("t5_ack", 32'(o_ack), 32'b0010);
    i_req = '0;
    tick();
    check("t5_no_draw", 32'(draw_total - d0), 0);
    check("t5_no_strobe", 32'(valid_total - v0), 0);

    // 6: reset on the second of four cards; priority returns to player 0
    load_deck(6'h31, 6'h32, 6'h33, 6'h34);
    i_req_num = 16'h4000;
    i_req = 4'b1000;
    a0 = ack_total;
    wait_valid("t6a");
    wait_valid("t6b");
    check("t6_card1", 32'(o_card), 32'h32);
    i_rst = 1'b1;
    tick();
    check_all_zero("t6_rst");
    i_rst = 1'b0;
    i_req = '0;
    repeat (10) tick();
    check("t6_no_ack", 32'(ack_total - a0), 0);
    check("t6_idle", 32'(o_busy), 0);
    i_req_num = 16'h1111;
    i_req = 4'b1111;
    tick();
    check("t6_first_grant", 32'(o_grant), 32'b0001);
    i_req = '0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
